// File: rtl/mem_arbiter_if.sv
// Reset bundle for mem_arbiter: one synchronous, active-low reset sampled on clk.
interface reset_if;
    logic rst_n;
    modport sink (input rst_n);
    modport source (output rst_n);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache (port 0) and the
// D-cache (port 1). One transaction at a time, round-robin on contention, the
// grant is held from accept through response.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a hung memory exchange
// after TIMEOUT_CYCLES cycles in ISSUE/WAIT and raise a sticky timeout_err.
module mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    reset_if.sink             rst_if,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op,
    input  logic [2*XLEN-1:0] req_addr,
    input  logic [2*XLEN-1:0] req_wdata,
    output logic [1:0]        resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_op,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              grant_id,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic            op;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    state_t   state_q, state_d;
    mem_req_t req_sel, req_q;
    logic     last_grant;
    logic     winner;
    logic     accept;
    logic     tmo;

    // A request is only taken in IDLE, and never while reset is held, so a
    // requester cannot see an accept pulse that the reset then discards.
    assign accept = rst_if.rst_n && (state_q == IDLE) && (|req_valid);

    // Pick the winner (alternate on contention, else the sole requester) and mux its payload.
    always_comb begin
        winner        = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        req_sel.op    = winner ? req_op[1]              : req_op[0];
        req_sel.addr  = winner ? req_addr[2*XLEN-1:XLEN]  : req_addr[XLEN-1:0];
        req_sel.wdata = winner ? req_wdata[2*XLEN-1:XLEN] : req_wdata[XLEN-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_if.rst_n) state_q <= IDLE;
        else               state_q <= state_d;
    end

    // Next-state logic and the combinational accept pulse.
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ISSUE;
                    req_ready = winner ? 2'b10 : 2'b01;
                end
            end
            ISSUE: begin
                if (mem_ready) state_d = WAIT;
                else if (tmo)  state_d = RESP;
            end
            WAIT: begin
                if (mem_resp_valid || tmo) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload capture, downstream request valid and the routed response.
    always_ff @(posedge clk) begin
        if (!rst_if.rst_n) begin
            req_q      <= '0;
            mem_valid  <= 1'b0;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            resp_valid <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q      <= req_sel;
                        grant_id   <= winner;
                        last_grant <= winner;
                        mem_valid  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                    end else if (tmo) begin
                        mem_valid  <= 1'b0;
                        resp_rdata <= '0;
                        resp_valid <= grant_id ? 2'b10 : 2'b01;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        // Writes are acknowledged with zero data.
                        resp_rdata <= req_q.op ? '0 : mem_rdata;
                        resp_valid <= grant_id ? 2'b10 : 2'b01;
                    end else if (tmo) begin
                        resp_rdata <= '0;
                        resp_valid <= grant_id ? 2'b10 : 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_op    = req_q.op;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        busy;

    // The watchdog fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT,
    // unless memory completes the current phase in that same cycle.
    assign busy = (state_q == ISSUE) || (state_q == WAIT);
    assign tmo  = busy && (wd_cnt == WD_LAST)
                  && !((state_q == ISSUE) && mem_ready)
                  && !((state_q == WAIT) && mem_resp_valid);

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_if.rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept)    wd_cnt <= '0;
            else if (busy) wd_cnt <= wd_cnt + 16'd1;
            if (tmo)       timeout_err <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_tmo_cfg = ^16'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps from the block's test plan followed by
// randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int XLEN = 32;
    localparam int TMO  = 10;

    logic              clk = 1'b0;
    logic [1:0]        req_valid, req_ready, req_op, resp_valid;
    logic [2*XLEN-1:0] req_addr, req_wdata;
    logic [XLEN-1:0]   resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic              mem_valid, mem_ready, mem_op, mem_resp_valid;
    logic              grant_id, timeout_err;

    int total = 0;
    int bad   = 0;

    // reference model state for the random phase
    bit          pend [2];
    logic        rop [2];
    logic [31:0] raddr [2];
    logic [31:0] rwdata [2];
    int          done_cnt [2];
    int          cyc, idle_at, rwait;
    bit          mv_exp, outst, resp_now;
    logic        last_g, owner, cop;
    logic [31:0] caddr, cwdata, exp_data;

    reset_if rst_if ();

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_if(rst_if),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // move to just after the next rising edge; inputs are driven here
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        rst_if.rst_n   = 1'b0;
        req_valid      = 2'b00;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        nxt();
        nxt();
        rst_if.rst_n = 1'b1;
    endtask

    // one transaction against a zero-wait memory, checked cycle by cycle
    task automatic zw_txn(input logic [1:0] rv, input bit hold, input int p, input logic [31:0] data);
        logic [31:0] ea;
        logic        eo;
        ea = req_addr[p*XLEN +: XLEN];
        eo = req_op[p];
        nxt(); req_valid = rv; #1;
        chk("zw_ready", 64'(req_ready), 64'(2'b01 << p));
        nxt(); if (!hold) req_valid = 2'b00; mem_ready = 1'b1; #1;
        chk("zw_mem_valid", 64'(mem_valid), 64'(1));
        chk("zw_mem_addr", 64'(mem_addr), 64'(ea));
        chk("zw_grant", 64'(grant_id), 64'(p));
        chk("zw_busy_ready", 64'(req_ready), 64'(0));
        nxt(); mem_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = data; #1;
        chk("zw_no_resp_yet", 64'(resp_valid), 64'(0));
        nxt(); mem_resp_valid = 1'b0; mem_rdata = $urandom; #1;
        chk("zw_resp_valid", 64'(resp_valid), 64'(2'b01 << p));
        chk("zw_resp_rdata", 64'(resp_rdata), eo ? 64'(0) : 64'(data));
    endtask

    // one cycle of random traffic; the model works at transaction level:
    // who should win, when the request must be visible, what comes back when
    task automatic rnd_cycle(input bit gen);
        logic [1:0] exp_rdy;
        logic       w;
        bit         hs, mresp;
        w = 1'b0;
        nxt();
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (gen && !pend[p] && $urandom_range(0, 2) == 0) begin
                pend[p]   = 1'b1;
                rop[p]    = 1'($urandom_range(0, 1));
                raddr[p]  = $urandom;
                rwdata[p] = $urandom;
            end
        end
        req_valid = {pend[1], pend[0]};
        req_op    = {rop[1], rop[0]};
        req_addr  = {raddr[1], raddr[0]};
        req_wdata = {rwdata[1], rwdata[0]};
        mem_ready = ($urandom_range(0, 2) != 0);
        mem_rdata = $urandom;
        if (outst) begin
            mresp = (rwait == 0);
            if (rwait > 0) rwait--;
        end else begin
            mresp = ($urandom_range(0, 3) == 0);   // stray pulses outside WAIT
        end
        mem_resp_valid = mresp;
        #1;
        exp_rdy = 2'b00;
        if (cyc >= idle_at && (pend[0] || pend[1])) begin
            w       = (pend[0] && pend[1]) ? ~last_g : pend[1];
            exp_rdy = w ? 2'b10 : 2'b01;
        end
        chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rnd_mem_valid", 64'(mem_valid), 64'(mv_exp));
        if (mv_exp) begin
            chk("rnd_mem_addr", 64'(mem_addr), 64'(caddr));
            chk("rnd_mem_op_wdata", 64'({mem_op, mem_wdata}), 64'({cop, cwdata}));
        end
        chk("rnd_resp_valid", 64'(resp_valid), resp_now ? (owner ? 64'(2) : 64'(1)) : 64'(0));
        if (resp_now) chk("rnd_resp_rdata", 64'(resp_rdata), 64'(exp_data));
        hs = mv_exp && mem_ready;
        if (resp_now) begin
            idle_at = cyc + 1;
            done_cnt[owner]++;
            resp_now = 1'b0;
        end
        if (outst && mresp) begin
            outst    = 1'b0;
            resp_now = 1'b1;
            exp_data = cop ? 32'd0 : mem_rdata;
        end
        if (hs) begin
            mv_exp = 1'b0;
            outst  = 1'b1;
            rwait  = $urandom_range(0, 3);
        end
        if (exp_rdy != 2'b00) begin
            owner   = w;
            last_g  = w;
            cop     = rop[w];
            caddr   = raddr[w];
            cwdata  = rwdata[w];
            pend[w] = 1'b0;
            mv_exp  = 1'b1;
            idle_at = 1 << 30;
        end
    endtask

    initial begin
        int n;
        rst_if.rst_n   = 1'b0;
        req_valid      = 2'b00;
        req_op         = 2'b00;
        req_addr       = '0;
        req_wdata      = '0;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        // reset state, with both requesters already asserting
        nxt(); nxt(); req_valid = 2'b11; #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_mem_payload", 64'({mem_op, mem_addr}), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        req_valid    = 2'b00;
        rst_if.rst_n = 1'b1;

        // single zero-wait read on port 0
        req_addr[31:0] = 32'h100;
        zw_txn(2'b01, 1'b0, 0, 32'hCAFE_F00D);

        // both ports held: strict alternation starting with port 0
        do_reset();
        req_addr = {32'h2000, 32'h1000};
        req_op   = 2'b00;
        for (int t = 0; t < 8; t++) zw_txn(2'b11, 1'b1, t % 2, $urandom | 32'h1);

        // reset while port 1 waits on memory; the old response is dropped
        nxt(); req_valid = 2'b10; #1;
        chk("rw_ready", 64'(req_ready), 64'(2));
        nxt(); req_valid = 2'b00; mem_ready = 1'b1; #1;
        chk("rw_mem_valid", 64'(mem_valid), 64'(1));
        nxt(); mem_ready = 1'b0; rst_if.rst_n = 1'b0; #1;
        nxt(); rst_if.rst_n = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("rw_mem_valid_clr", 64'(mem_valid), 64'(0));
        chk("rw_resp_rdata_clr", 64'(resp_rdata), 64'(0));
        chk("rw_grant_clr", 64'(grant_id), 64'(0));
        chk("rw_mem_addr_clr", 64'(mem_addr), 64'(0));
        nxt(); mem_resp_valid = 1'b0; #1;
        chk("rw_old_resp_dropped", 64'(resp_valid), 64'(0));
        zw_txn(2'b01, 1'b0, 0, 32'h1111_2222);

        // stray response while idle
        nxt(); mem_resp_valid = 1'b1; mem_rdata = $urandom; #1;
        nxt(); mem_resp_valid = 1'b0; #1;
        chk("idle_stray_resp", 64'({resp_valid, mem_valid}), 64'(0));

        // port 1 write, memory stalls 5 cycles, stray response during ISSUE
        req_addr[63:32]  = 32'h40;
        req_wdata[63:32] = 32'h1234_5678;
        req_op[1]        = 1'b1;
        nxt(); req_valid = 2'b10; #1;
        chk("wr_ready", 64'(req_ready), 64'(2));
        for (int k = 0; k < 6; k++) begin
            nxt(); req_valid = 2'b00; mem_ready = (k == 5); mem_resp_valid = (k == 2); #1;
            chk("wr_mem_valid", 64'(mem_valid), 64'(1));
            chk("wr_mem_addr", 64'(mem_addr), 64'(32'h40));
            chk("wr_mem_op_wdata", 64'({mem_op, mem_wdata}), 64'({1'b1, 32'h1234_5678}));
            chk("wr_no_early_resp", 64'(resp_valid), 64'(0));
        end
        nxt(); mem_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        chk("wr_mem_valid_drop", 64'(mem_valid), 64'(0));
        chk("wr_resp_wait", 64'(resp_valid), 64'(0));
        nxt(); mem_resp_valid = 1'b0; #1;
        chk("wr_resp_valid", 64'(resp_valid), 64'(2));
        chk("wr_resp_rdata", 64'(resp_rdata), 64'(0));

        // random traffic against the model; last grant so far was port 1
        cyc = 0; idle_at = 0; last_g = 1'b1; owner = 1'b0;
        mv_exp = 1'b0; outst = 1'b0; resp_now = 1'b0; rwait = 0;
        cop = 1'b0; caddr = '0; cwdata = '0; exp_data = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; rop[p] = 1'b0; raddr[p] = '0; rwdata[p] = '0; done_cnt[p] = 0;
        end
        for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
        n = 0;
        while ((pend[0] || pend[1] || cyc < idle_at) && n < 500) begin
            rnd_cycle(1'b0);
            n++;
        end
        chk("rnd_drained", 64'({pend[0], pend[1], cyc < idle_at}), 64'(0));
        chk("rnd_both_served", 64'((done_cnt[0] > 0) && (done_cnt[1] > 0)), 64'(1));
        nxt(); req_valid = 2'b00; mem_ready = 1'b0; mem_resp_valid = 1'b0; #1;

`ifdef MEM_ARB_TIMEOUT_EN
        // memory takes the request but never answers
        req_addr[31:0] = 32'h300;
        req_op[0]      = 1'b0;
        nxt(); req_valid = 2'b01; #1;
        chk("tmo_ready", 64'(req_ready), 64'(1));
        nxt(); req_valid = 2'b00; mem_ready = 1'b1; #1;
        nxt(); mem_ready = 1'b0; #1;
        n = 2;
        while (resp_valid == 2'b00 && n < 40) begin
            nxt(); n++; #1;
        end
        chk("tmo_resp_cycle", 64'(n), 64'(TMO + 1));
        chk("tmo_resp_valid", 64'(resp_valid), 64'(1));
        chk("tmo_resp_rdata", 64'(resp_rdata), 64'(0));
        chk("tmo_err_set", 64'(timeout_err), 64'(1));
        nxt(); mem_resp_valid = 1'b1; #1;
        nxt(); mem_resp_valid = 1'b0; #1;
        chk("tmo_late_ignored", 64'(resp_valid), 64'(0));
        chk("tmo_err_sticky", 64'(timeout_err), 64'(1));
        do_reset();
        #1;
        chk("tmo_err_reset", 64'(timeout_err), 64'(0));
`else
        chk("timeout_err_tied", 64'(timeout_err), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single lower-level memory port (hmem) between the instruction cache (port 0) and the data cache (port 1). Sits between both cache controllers and main memory; accepts one transaction at a time, grants round-robin, holds the grant for the whole request/response exchange, and routes the response back to the winning cache. Optional watchdog aborts a hung memory transaction.

## Interface
- XLEN, 32, address/data width in bits
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN); min 2, max 2^16-1

- clk  input  1  system clock, all logic on rising edge
- rst_if  input  reset_if  one clock; reset is synchronous and active-low (rst_if.rst_n, sampled on clk)
- req_valid  input  2  per-port request valid; bit i = port i
- req_ready  output  2  per-port accept pulse (one-hot or zero)
- req_op  input  2  per-port op: 0 read, 1 write
- req_addr  input  2*XLEN  per-port address, port i at [i*XLEN +: XLEN]
- req_wdata  input  2*XLEN  per-port write data, same packing
- resp_valid  output  2  per-port response pulse (one-hot or zero)
- resp_rdata  output  XLEN  read data, qualified by resp_valid
- mem_valid  output  1  downstream request valid
- mem_ready  input  1  downstream accepts request when mem_valid & mem_ready
- mem_op, mem_addr, mem_wdata  output  1/XLEN/XLEN  downstream request payload
- mem_resp_valid  input  1  downstream response/ack pulse
- mem_rdata  input  XLEN  downstream read data, qualified by mem_resp_valid
- grant_id  output  1  port currently owning the memory (valid when state != IDLE)
- timeout_err  output  1  sticky watchdog error flag

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, select winner: if both valid, the port != last_grant; else the sole requester. Pulse req_ready[winner], capture op/addr/wdata into payload registers, set grant_id and last_grant = winner, go ISSUE.
- ISSUE: mem_valid=1 with captured payload; on mem_ready go WAIT.
- WAIT: on mem_resp_valid capture mem_rdata (reads) or 0 (writes) into resp_rdata register, go RESP.
- RESP: resp_valid[grant_id]=1 for exactly this cycle; go IDLE.
- Requesters hold req_valid and payload stable until req_ready; arbiter never inspects payload after capture.
- mem_resp_valid in IDLE, ISSUE or RESP is ignored (no state change, no response).
- req_valid on the non-granted port while busy is held off; it wins the next IDLE arbitration.
- Reset (rst_n=0 at a clk edge) from any state: state=IDLE, all outputs 0, resp_rdata=0, grant_id=0, last_grant=1 (port 0 wins first contention), timeout_err=0, watchdog counter=0. Any in-flight transaction is dropped silently.

## Timing
- req_ready combinational from state==IDLE and req_valid; all other outputs registered.
- Zero-wait memory (mem_ready same cycle, mem_resp_valid next cycle): accept cycle 0, mem_valid cycle 1, mem_resp_valid cycle 2, resp_valid cycle 3, next accept cycle 4. Port-to-port throughput: one transaction per 4 cycles minimum.
- mem_valid stays high and payload stable from ISSUE entry until the mem_ready cycle inclusive.
- Exactly one resp_valid pulse per req_ready pulse (timeout included).

## Configuration
- MEM_ARB_TIMEOUT_EN defined: 16-bit counter clears on IDLE->ISSUE, increments each cycle in ISSUE/WAIT. When count reaches TIMEOUT_CYCLES without leaving WAIT: deassert mem_valid, go RESP with resp_rdata=0, set timeout_err (cleared only by reset). Late mem_resp_valid afterward is ignored per IDLE rule.
- Undefined: no counter; timeout_err tied 0; arbiter waits indefinitely in ISSUE/WAIT.

## Test plan
- Single read port 0, addr 0x100, memory returns 0xCAFE_F00D with zero wait -> req_ready[0] cycle 0, mem_addr=0x100 cycle 1, resp_valid=2'b01 with resp_rdata=0xCAFE_F00D cycle 3.
- Both ports valid at reset release -> port 0 granted first, port 1 granted in the following IDLE; repeat both held continuously for 8 transactions -> strict alternation 0,1,0,1...
- Port 1 write addr 0x40 wdata 0x1234_5678, mem_ready delayed 5 cycles -> mem_valid/payload stable all 6 cycles, resp_valid=2'b10 with resp_rdata=0.
- Spurious mem_resp_valid while IDLE and during ISSUE -> no resp_valid, state unchanged.
- Reset asserted during WAIT, then port 0 read -> all outputs 0 after reset edge, new transaction completes normally, old response dropped.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, memory never responds -> resp_valid to grantee with rdata 0 after 10 cycles, timeout_err=1 and stays high until reset.
